// File: rtl/bcd9999_scan_pkg.sv
// Shared constants and types for the four-digit BCD counter and display scanner.
// Included by the counter top and its decade sub-module.
package bcd9999_scan_pkg;

  localparam int         NUM_DIGITS   = 4;
  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] DIG_SEL_IDLE = 4'b1111;

  typedef logic [1:0] dig_idx_t;

  // Active-low select with only the indexed digit driven.
  function automatic logic [3:0] dig_sel_onehot_n(input dig_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd9999_scan_bcd_digit.sv
// One BCD decade (0..9) with increment, decrement and synchronous clear.
// Carry and borrow are combinational so that four decades ripple in a single cycle.
module bcd_digit
  import bcd9999_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] digit_o,
  output logic       carry_o,
  output logic       borrow_o
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = 4'd0;
    end else if (inc_i) begin
      digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
    end else if (dec_i) begin
      digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
    end else begin
      digit_d = digit_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o  = digit_q;
  assign carry_o  = inc_i && (digit_q == BCD_MAX);
  assign borrow_o = dec_i && (digit_q == 4'd0);

endmodule

// File: rtl/bcd9999_scan.sv
// Four-digit BCD up/down counter with a count prescaler and a time-multiplexed
// digit scanner that feeds the seven-segment decoder and the active-low digit selects.
module bcd9999_scan
  import bcd9999_scan_pkg::*;
#(
  parameter int CNT_DIV  = 50_000_000,
  parameter int SCAN_DIV = 50_000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        up_i,
  input  logic        clr_i,
  output logic [15:0] value_o,
  output logic        wrap_o,
  output logic [3:0]  hex_o,
  output logic [3:0]  dig_sel_o
);

  localparam int PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(CNT_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] scan_q, scan_d;
  dig_idx_t      idx_q, idx_d;
  logic          wrap_q, wrap_d;
  logic [3:0]    hex_q, hex_d;
  logic [3:0]    sel_q, sel_d;
  logic          tick_s;
  logic [3:0]    d0_s, d1_s, d2_s, d3_s;
  logic          c0_s, c1_s, c2_s, c3_s;
  logic          b0_s, b1_s, b2_s, b3_s;
  logic [3:0]    blank_s;

  assign tick_s = en_i && (pre_q == PRE_LAST);

  // Ripple chain: units digit steps on the tick, higher digits on carry/borrow.
  bcd_digit u_d0 (.clk(clk), .rst_n(rst_n), .clr_i(clr_i), .inc_i(tick_s && up_i),
                  .dec_i(tick_s && !up_i), .digit_o(d0_s), .carry_o(c0_s), .borrow_o(b0_s));
  bcd_digit u_d1 (.clk(clk), .rst_n(rst_n), .clr_i(clr_i), .inc_i(c0_s),
                  .dec_i(b0_s), .digit_o(d1_s), .carry_o(c1_s), .borrow_o(b1_s));
  bcd_digit u_d2 (.clk(clk), .rst_n(rst_n), .clr_i(clr_i), .inc_i(c1_s),
                  .dec_i(b1_s), .digit_o(d2_s), .carry_o(c2_s), .borrow_o(b2_s));
  bcd_digit u_d3 (.clk(clk), .rst_n(rst_n), .clr_i(clr_i), .inc_i(c2_s),
                  .dec_i(b2_s), .digit_o(d3_s), .carry_o(c3_s), .borrow_o(b3_s));

  always_comb begin
    pre_d  = pre_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      pre_d  = '0;
      wrap_d = 1'b0;
    end else if (tick_s) begin
      pre_d  = '0;
      wrap_d = c3_s || b3_s;
    end else if (en_i) begin
      pre_d  = pre_q + PW'(1);
    end else begin
      pre_d  = pre_q;
    end
  end

  always_comb begin
    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end else begin
      idx_d  = idx_q;
    end
  end

  // A digit is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    blank_s = 4'b0000;
    if (BLANK_LZ) begin
      blank_s[3] = (d3_s == 4'd0);
      blank_s[2] = blank_s[3] && (d2_s == 4'd0);
      blank_s[1] = blank_s[2] && (d1_s == 4'd0);
      blank_s[0] = 1'b0;
    end else begin
      blank_s = 4'b0000;
    end
  end

  always_comb begin
    hex_d = 4'd0;
    case (idx_q)
      2'd0:    hex_d = d0_s;
      2'd1:    hex_d = d1_s;
      2'd2:    hex_d = d2_s;
      2'd3:    hex_d = d3_s;
      default: hex_d = 4'd0;
    endcase
    sel_d = blank_s[idx_q] ? DIG_SEL_IDLE : dig_sel_onehot_n(idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      scan_q <= '0;
      idx_q  <= 2'd0;
      wrap_q <= 1'b0;
      hex_q  <= 4'd0;
      sel_q  <= 4'b1110;
    end else begin
      pre_q  <= pre_d;
      scan_q <= scan_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      hex_q  <= hex_d;
      sel_q  <= sel_d;
    end
  end

  assign value_o   = {d3_s, d2_s, d1_s, d0_s};
  assign wrap_o    = wrap_q;
  assign hex_o     = hex_q;
  assign dig_sel_o = sel_q;

endmodule

// File: doc/bcd9999_scan.md
Name: bcd9999_scan

Overview:
- Four-digit BCD up/down counter (0000–9999) with a clock prescaler and a time-multiplexed digit scanner.
- Sits directly upstream of the seven-segment decoder: drives its 4-bit `hex` input with the currently selected digit.
- Also drives the active-low digit-select lines for the four-digit display.

Parameters:
- CNT_DIV, 50_000_000: clk cycles per count step; legal range >= 1.
- SCAN_DIV, 50_000: clk cycles per digit scan slot; legal range >= 1.
- BLANK_LZ, 1: 1 = blank leading zeros on digits 3..1; digit 0 is never blanked.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; prescaler advances only while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear of count and prescaler.
- value  out  16  current count, BCD {d3,d2,d1,d0}, d0 = units.
- wrap  out  1  one-cycle pulse on 9999->0000 (up) or 0000->9999 (down).
- hex  out  4  selected digit to the seven-segment decoder.
- dig_sel  out  4  active-low digit enable; bit i drives digit i.

Behaviour:
- Reset (rst_n low, asynchronous): all internal state cleared.
  - value=16'h0000, wrap=0, hex=4'h0, dig_sel=4'b1110.
  - Prescaler=0, scan counter=0, scan index=0.
  - Release is synchronous to clk; first count tick comes CNT_DIV enabled cycles after release.
- Prescaler: counts 0..CNT_DIV-1 while en=1 and holds while en=0.
  - The count tick fires in the cycle where prescaler==CNT_DIV-1 and en=1; the prescaler then returns to 0.
  - CNT_DIV=1: tick every enabled cycle.
  - Width is $clog2(CNT_DIV), minimum 1.
- Count step on tick:
  - value updates at the clock edge ending the tick cycle.
  - Up: d0+1; a digit at 9 goes to 0 and carries into the next digit. 9999 -> 0000 with wrap=1 for exactly that one cycle.
  - Down: d0-1; a digit at 0 goes to 9 and borrows from the next digit. 0000 -> 9999 with wrap=1.
  - Each digit stays in 0..9 at all times; non-BCD nibbles are unreachable.
- clr: highest priority after reset.
  - Next edge: value=0000, prescaler=0, wrap=0.
  - A tick in the same cycle is discarded, with no wrap, even from 9999 up.
- up changing mid-count: takes effect on the next tick; the prescaler is unaffected.
- Scanner: free-running and independent of en and clr.
  - Scan counter counts 0..SCAN_DIV-1; at terminal count the scan index advances 0->1->2->3->0.
- Display outputs are registered, with 1-cycle latency from a change of scan index or digit value.
  - hex = digit[index].
  - dig_sel = ~(4'b0001 << index), except when the digit is blanked, then dig_sel = 4'b1111.
  - A digit is blanked when BLANK_LZ=1 and it and all higher digits are 0. Digit 0 is never blanked.
  - value 0000 shows a single "0".
- wrap is registered and is never high for two consecutive cycles unless CNT_DIV=1 and the counter genuinely wraps twice.

Decomposition:
- Shared package (counter9999 project), constants:
  - NUM_DIGITS=4.
  - BCD_MAX=4'd9.
  - DIG_SEL_IDLE=4'b1111.
  - Digit index type of 2 bits.
- Sub-module bcd_digit: one decade with inc/dec/clr inputs and carry/borrow out; bcd9999_scan instantiates four in a ripple chain.
- Prescaler, scanner and output registers live in the top.

Test Plan:
All scenarios use CNT_DIV=4, SCAN_DIV=2, BLANK_LZ=1.
- Reset mid-operation: count to 0037, pulse rst_n low between edges -> value=0000, dig_sel=1110, hex=0 immediately (asynchronous); first tick occurs 4 enabled cycles after release.
- Ripple up: clr, then 100 ticks with up=1 -> value goes 0099 -> 0100 on the 100th tick, wrap stays 0. Toggling en low for 3 cycles delays the next tick by exactly 3 cycles.
- Up wrap: preload by counting to 9999 -> next tick gives value=0000 and wrap=1 for exactly one cycle.
- Down wrap/borrow: from 0000 with up=0 -> one tick gives 9999 with wrap=1. Further ticks give 9998, and 1000 -> 0999 on a borrow chain.
- clr collision: value=9999, up=1, clr asserted in the tick cycle -> value=0000, wrap=0, prescaler=0.
- Scan and blanking: value=0042, observe 8 slots.
  - dig_sel sequence 1110, 1101, 1111, 1111 repeating.
  - hex shows 2, then 4, in slots 0 and 1.
  - value=0000 -> only slot 0 is active (1110, hex=0).
